// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop; each bit PRESCALE clks.
// Accept -> start bit on the next edge; DATA_VALID is only taken in IDLE or on the last stop tick, otherwise ignored.
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [TW-1:0]         r_tick;
   logic [BW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_nxt;
   logic                  r_par_en;
   logic                  r_par_bit;
   logic                  w_last_tick;
   logic                  w_last_bit;
   logic                  w_accept;
   logic                  w_tx_nxt;
   logic                  w_busy_nxt;

   assign w_last_tick = (r_tick == TW'(PRESCALE - 1));
   assign w_last_bit  = (r_bit_cnt == BW'(DATA_WIDTH - 1));
   assign w_accept    = DATA_VALID && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last_tick));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_START;
         S_START:  if (w_last_tick) w_state_nxt = S_DATA;
         S_DATA:   if (w_last_tick && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (w_last_tick) w_state_nxt = S_STOP;
         S_STOP: begin
            if (w_accept)         w_state_nxt = S_START;
            else if (w_last_tick) w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_shift_nxt = r_shift;
      if (w_accept)                              w_shift_nxt = P_DATA;
      else if ((r_state == S_DATA) && w_last_tick) w_shift_nxt = r_shift >> 1;
   end

   // Outputs are decoded from the next state so TX_OUT/busy can be registered without a cycle of lag.
   always_comb begin
      w_tx_nxt   = 1'b1;
      w_busy_nxt = 1'b1;
      case (w_state_nxt)
         S_IDLE:   w_busy_nxt = 1'b0;
         S_START:  w_tx_nxt   = 1'b0;
         S_DATA:   w_tx_nxt   = w_shift_nxt[0];
         S_PARITY: w_tx_nxt   = r_par_bit;
         S_STOP:   w_tx_nxt   = 1'b1;
         default:  w_busy_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tick    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         TX_OUT    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         if (w_accept || w_last_tick || (r_state == S_IDLE)) r_tick <= '0;
         else                                                r_tick <= r_tick + TW'(1);

         if ((r_state == S_START) && w_last_tick)
            r_bit_cnt <= '0;
         else if ((r_state == S_DATA) && w_last_tick && !w_last_bit)
            r_bit_cnt <= r_bit_cnt + BW'(1);

         if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_bit <= PAR_TYP ? ~^P_DATA : ^P_DATA;
         end

         r_shift <= w_shift_nxt;
         TX_OUT  <= w_tx_nxt;
         busy    <= w_busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: PRESCALE=8 instance for framing/parity/abort cases, PRESCALE=1 instance for 1-clk bits.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       tx_out;
   logic       busy;

   logic [7:0] p_data1;
   logic       data_valid1;
   logic       par_en1;
   logic       par_typ1;
   logic       tx_out1;
   logic       busy1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8), .PRESCALE(8)) u_dut (
      .clk(clk), .reset(reset), .P_DATA(p_data), .DATA_VALID(data_valid),
      .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx_out), .busy(busy)
   );

   uart_tx #(.DATA_WIDTH(8), .PRESCALE(1)) u_dut1 (
      .clk(clk), .reset(reset), .P_DATA(p_data1), .DATA_VALID(data_valid1),
      .PAR_EN(par_en1), .PAR_TYP(par_typ1), .TX_OUT(tx_out1), .busy(busy1)
   );

   // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
   task automatic send(input logic [7:0] d, input logic pe, input logic pt);
      p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
      p_data1 = '0; data_valid1 = 1'b0; par_en1 = 1'b0; par_typ1 = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL reset_state tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
      end
      checks++;
      if (tx_out1 !== 1'b1 || busy1 !== 1'b0) begin
         failures++; $display("FAIL reset_state_p1 tx=%b busy=%b expected tx=1 busy=0", tx_out1, busy1);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
      end
   endtask

   task automatic test_frame_nopar;
      logic [9:0] exp;
      exp = 10'b1_10100101_0;
      send(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 80; i++) begin
         checks++;
         if (tx_out !== exp[i/8] || busy !== 1'b1) begin
            failures++; $display("FAIL a5_frame cyc=%0d tx=%b busy=%b expected tx=%b busy=1", i, tx_out, busy, exp[i/8]);
         end
         @(negedge clk);
      end
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL a5_end tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
      end
   endtask

   task automatic test_parity;
      logic [10:0] exp;
      for (int t = 0; t < 2; t++) begin
         exp = (t == 0) ? 11'b1_1_00000111_0 : 11'b1_0_00000111_0;
         send(8'h07, 1'b1, t[0]);
         for (int i = 0; i < 88; i++) begin
            checks++;
            if (tx_out !== exp[i/8] || busy !== 1'b1) begin
               failures++; $display("FAIL parity_frame typ=%0d cyc=%0d tx=%b busy=%b expected tx=%b busy=1", t, i, tx_out, busy, exp[i/8]);
            end
            if (i == 20) begin
               par_en = 1'b0; par_typ = ~par_typ; p_data = 8'hF0;
            end
            @(negedge clk);
         end
         checks++;
         if (tx_out !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL parity_end typ=%0d tx=%b busy=%b expected tx=1 busy=0", t, tx_out, busy);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [19:0] exp;
      exp = 20'b1_10101010_0_1_01010101_0;
      p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 160; i++) begin
         checks++;
         if (tx_out !== exp[i/8] || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_frame cyc=%0d tx=%b busy=%b expected tx=%b busy=1", i, tx_out, busy, exp[i/8]);
         end
         if (i == 1)  p_data = 8'hAA;
         if (i == 80) data_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL b2b_end tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
      end
   endtask

   task automatic test_ignore_midframe;
      logic [9:0] exp;
      exp = 10'b1_00000000_0;
      send(8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 80; i++) begin
         checks++;
         if (tx_out !== exp[i/8] || busy !== 1'b1) begin
            failures++; $display("FAIL ignore_frame cyc=%0d tx=%b busy=%b expected tx=%b busy=1", i, tx_out, busy, exp[i/8]);
         end
         if (i == 34) begin p_data = 8'hFF; data_valid = 1'b1; end
         if (i == 35) data_valid = 1'b0;
         @(negedge clk);
      end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (tx_out !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL ignore_no_extra cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, tx_out, busy);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midframe;
      logic [9:0] exp;
      exp = 10'b1_11000011_0;
      send(8'hC3, 1'b0, 1'b0);
      for (int i = 0; i < 43; i++) begin
         checks++;
         if (tx_out !== exp[i/8] || busy !== 1'b1) begin
            failures++; $display("FAIL abort_prefix cyc=%0d tx=%b busy=%b expected tx=%b busy=1", i, tx_out, busy, exp[i/8]);
         end
         @(negedge clk);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_async tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_idle tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
      end
      exp = 10'b1_00111100_0;
      send(8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 80; i++) begin
         checks++;
         if (tx_out !== exp[i/8] || busy !== 1'b1) begin
            failures++; $display("FAIL post_abort_frame cyc=%0d tx=%b busy=%b expected tx=%b busy=1", i, tx_out, busy, exp[i/8]);
         end
         @(negedge clk);
      end
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL post_abort_end tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
      end
   endtask

   task automatic test_prescale1;
      logic [19:0] exp;
      exp = 20'b1_00001111_0_1_10000001_0;
      p_data1 = 8'h81; data_valid1 = 1'b1;
      @(negedge clk);
      data_valid1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (tx_out1 !== exp[i] || busy1 !== 1'b1) begin
            failures++; $display("FAIL p1_frame cyc=%0d tx=%b busy=%b expected tx=%b busy=1", i, tx_out1, busy1, exp[i]);
         end
         if (i == 9)  begin p_data1 = 8'h0F; data_valid1 = 1'b1; end
         if (i == 10) data_valid1 = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (tx_out1 !== 1'b1 || busy1 !== 1'b0) begin
         failures++; $display("FAIL p1_end tx=%b busy=%b expected tx=1 busy=0", tx_out1, busy1);
      end
   endtask

   initial begin
      test_reset();
      test_frame_nopar();
      test_parity();
      test_back_to_back();
      test_ignore_midframe();
      test_reset_midframe();
      test_prescale1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
